sabr_mul_rescale_stage: RTL and testbench
=========================================

// Module: sabr_mul_rescale_stage
// PURPOSE
//  Issue/retire wrapper around the SABR 40x40->79 pipelined unsigned multiplier.
//  Takes Q-format operand pairs over valid/ready, drives the multiplier, and tracks in-flight ops.
//  Rescales each product by FRAC_BITS with round-half-up and saturation to OUT_WIDTH.
//  Buffers results in a FWFT FIFO. Sits between the path-update datapath and the multiplier core.
// PARAMETERS
//  IN_WIDTH     39  operand magnitude width (unsigned); zero-extended onto the multiplier inputs
//  MUL_WIDTH    40  multiplier din0/din1 width
//  PROD_WIDTH   79  multiplier dout width
//  OUT_WIDTH    40  rescaled result width
//  FRAC_BITS    32  fractional bits of each operand; must be >=1
//  MUL_LATENCY  1   edges from mul_din change to matching mul_dout (while mul_ce=1)
//  FIFO_DEPTH   4   result FIFO entries; power of two, >=2
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  reset_n    in   1           synchronous, active-low reset
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           block can accept operand pair
//  in_a       in   IN_WIDTH    operand A, unsigned, FRAC_BITS fraction
//  in_b       in   IN_WIDTH    operand B, unsigned, FRAC_BITS fraction
//  mul_ce     out  1           multiplier clock enable
//  mul_din0   out  MUL_WIDTH   multiplier operand 0 (registered)
//  mul_din1   out  MUL_WIDTH   multiplier operand 1 (registered)
//  mul_dout   in   PROD_WIDTH  multiplier product
//  out_valid  out  1           result at FIFO head valid
//  out_ready  in   1           consumer takes head when out_valid
//  out_data   out  OUT_WIDTH   rescaled result
//  out_sat    out  1           head result was saturated
//  sat_count  out  16          saturating count of saturated results written
//  busy       out  1           any op in flight or FIFO non-empty
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): credit=FIFO_DEPTH, valid pipe=0, FIFO empty.
//    Outputs while in reset: in_ready=0, mul_ce=0, mul_din0/1=0, out_valid=0, out_data=0,
//    out_sat=0, sat_count=0, busy=0.
//  - Reset mid-operation drops all in-flight ops and FIFO contents. Stale mul_dout is never
//    written, because the valid pipe is cleared. The multiplier itself has no reset.
//  - mul_ce=1 from the first edge after reset release. The block never stalls the multiplier.
//  - Credit counter (0..FIFO_DEPTH) = FIFO_DEPTH - in_flight - occupancy.
//    in_ready = (credit!=0) && !reset.
//  - Accept: in_valid&&in_ready at edge k. At edge k:
//    mul_din0<={0,in_a}, mul_din1<={0,in_b}, credit-1, valid_pipe[0]<=1.
//    mul_din holds its value when there is no accept.
//  - valid_pipe is MUL_LATENCY+1 deep. When the tail bit is set, mul_dout is rescaled
//    and written to the FIFO at edge k+MUL_LATENCY+1.
//    out_valid is visible in the cycle after that edge. No bypass, even when the FIFO is empty.
//  - Pop: out_valid&&out_ready at an edge gives credit+1.
//    Accept and pop on the same edge leave credit unchanged.
//  - The credit rule guarantees the FIFO is never written when full. A write and a pop on the
//    same edge are legal at any occupancy. An empty FIFO ignores out_ready.
//  - Rescale: r = (P + 2^(FRAC_BITS-1)) >> FRAC_BITS, with the sum computed at PROD_WIDTH+1 bits.
//    If r >= 2^OUT_WIDTH: data = all ones, sat=1. Else data = r[OUT_WIDTH-1:0], sat=0.
//  - sat_count increments on each FIFO write with sat=1 and holds at 0xFFFF.
//  - Results leave in strict acceptance order. No drops, no duplicates.
//  - busy = (credit != FIFO_DEPTH).
// TESTING
//  1. Reset_n low 3 cycles while 2 ops are in flight.
//     -> No out_valid afterwards; in_ready=1 at the first edge after release; sat_count=0.
//  2. in_a=0x1_0000_0000 (1.0), in_b=0x2_8000_0000 (2.5), out_ready=1.
//     -> out_data=0x2_8000_0000, out_sat=0, out_valid 2 cycles after accept.
//  3. in_a=1, in_b=0x8000_0000 -> out_data=1 (round up).
//     in_a=1, in_b=0x7FFF_FFFF -> out_data=0.
//  4. in_a=in_b=0x7F_FFFF_FFFF -> out_data=0xFF_FFFF_FFFF, out_sat=1, sat_count=1.
//     Repeat 70000 times -> sat_count=0xFFFF.
//  5. out_ready=0, in_valid=1 for 6 distinct ops.
//     -> exactly 4 accepted, in_ready=0, busy=1.
//     Then out_ready=1 -> all 6 results in order, no loss.
//  6. Sustained in_valid=out_ready=1 for 100 ops.
//     -> 1 result/cycle after fill, in_ready never drops, outputs match a reference model.

Source files
------------

// File: rtl/sabr_mul_rescale_stage.sv
// Issue/retire wrapper around the SABR pipelined unsigned multiplier.
// Accepts Q-format operand pairs, tracks in-flight ops with a credit counter,
// rescales each product (round-half-up, saturating) and buffers results in a
// first-word-fall-through FIFO with registered head outputs.
module sabr_mul_rescale_stage #(
  parameter int unsigned IN_WIDTH    = 39,
  parameter int unsigned MUL_WIDTH   = 40,
  parameter int unsigned PROD_WIDTH  = 79,
  parameter int unsigned OUT_WIDTH   = 40,
  parameter int unsigned FRAC_BITS   = 32,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_a,
  input  logic [IN_WIDTH-1:0]   in_b,
  output logic                  mul_ce,
  output logic [MUL_WIDTH-1:0]  mul_din0,
  output logic [MUL_WIDTH-1:0]  mul_din1,
  input  logic [PROD_WIDTH-1:0] mul_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic [15:0]           sat_count,
  output logic                  busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = PROD_WIDTH + 1;
  localparam int unsigned VP_W  = MUL_LATENCY + 1;

  logic [CNT_W-1:0]     credit, credit_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [VP_W-1:0]      valid_pipe;
  logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                 mem_sat  [FIFO_DEPTH];

  logic                 accept_c, pop_c, wr_c;
  logic [SUM_W-1:0]     rnd_sum_c, shifted_c;
  logic                 res_sat_c;
  logic [OUT_WIDTH-1:0] res_data_c;
  logic [OUT_WIDTH-1:0] head_data_c;
  logic                 head_sat_c;

  assign accept_c = in_valid & in_ready;
  assign pop_c    = out_valid & out_ready;
  assign wr_c     = valid_pipe[VP_W-1];

  // Rescale the product: add half an LSB, drop the fraction, saturate on overflow
  always_comb begin
    rnd_sum_c  = SUM_W'(mul_dout) + (SUM_W'(1) << (FRAC_BITS - 1));
    shifted_c  = rnd_sum_c >> FRAC_BITS;
    res_sat_c  = |shifted_c[SUM_W-1:OUT_WIDTH];
    res_data_c = res_sat_c ? {OUT_WIDTH{1'b1}} : shifted_c[OUT_WIDTH-1:0];
  end

  // Next-state for credit, FIFO pointers/occupancy and the post-edge head entry
  always_comb begin
    credit_nxt  = credit;
    count_nxt   = count;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    head_data_c = '0;
    head_sat_c  = 1'b0;

    if (accept_c && !pop_c)      credit_nxt = credit - CNT_W'(1);
    else if (pop_c && !accept_c) credit_nxt = credit + CNT_W'(1);

    if (wr_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (pop_c && !wr_c) count_nxt = count - CNT_W'(1);

    if (wr_c)  wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pop_c) rd_ptr_nxt = rd_ptr + PTR_W'(1);

    // The only way the write lands on the new head slot is when the FIFO drains to empty
    if (wr_c && (wr_ptr == rd_ptr_nxt)) begin
      head_data_c = res_data_c;
      head_sat_c  = res_sat_c;
    end else begin
      head_data_c = mem_data[rd_ptr_nxt];
      head_sat_c  = mem_sat[rd_ptr_nxt];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credit     <= CNT_W'(FIFO_DEPTH);
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_pipe <= '0;
      in_ready   <= 1'b0;
      mul_ce     <= 1'b0;
      mul_din0   <= '0;
      mul_din1   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      sat_count  <= '0;
      busy       <= 1'b0;
    end else begin
      credit     <= credit_nxt;
      count      <= count_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      valid_pipe <= (valid_pipe << 1) | VP_W'(accept_c);
      in_ready   <= (credit_nxt != '0);
      mul_ce     <= 1'b1;
      if (accept_c) begin
        mul_din0 <= MUL_WIDTH'(in_a);
        mul_din1 <= MUL_WIDTH'(in_b);
      end
      out_valid  <= (count_nxt != '0);
      out_data   <= head_data_c;
      out_sat    <= head_sat_c;
      if (wr_c && res_sat_c && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
      busy       <= (credit_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (reset_n && wr_c) begin
      mem_data[wr_ptr] <= res_data_c;
      mem_sat[wr_ptr]  <= res_sat_c;
    end
  end

endmodule

// File: tb/tb_sabr_mul_rescale_stage.sv
// Directed bench for sabr_mul_rescale_stage with a latency-1 multiplier model.
module tb_sabr_mul_rescale_stage;

  localparam int unsigned IW = 39;
  localparam int unsigned MW = 40;
  localparam int unsigned PW = 79;
  localparam int unsigned OW = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_a, in_b;
  logic          mul_ce;
  logic [MW-1:0] mul_din0, mul_din1;
  logic [PW-1:0] mul_dout;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_sat;
  logic [15:0]   sat_count;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [40:0] exp_q[$];

  logic [79:0] prod_full;
  logic [IW-1:0] opa [6] = '{39'h1_0000_0000, 39'h3, 39'h12_3456_789A, 39'h7F_FFFF_FFFF, 39'h0, 39'h2_0000_0000};
  logic [IW-1:0] opb [6] = '{39'h5_0000_0000, 39'h4000_0000, 39'h1_0000_0000, 39'h7F_FFFF_FFFF, 39'h55, 39'h1_8000_0000};

  always #5 clk = ~clk;

  sabr_mul_rescale_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_count(sat_count), .busy(busy)
  );

  // Multiplier core model: product appears one edge after din changes
  assign prod_full = {40'b0, mul_din0} * {40'b0, mul_din1};
  always_ff @(posedge clk) begin
    if (mul_ce) mul_dout <= prod_full[PW-1:0];
  end

  function automatic logic [40:0] ref_out(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [79:0] p, s, r;
    p = {41'b0, a} * {41'b0, b};
    s = p + (80'd1 << 31);
    r = s >> 32;
    if (r > 80'h00FF_FFFF_FFFF) return {1'b1, 40'hFF_FFFF_FFFF};
    return {1'b0, r[39:0]};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Account handshakes seen with current inputs, then advance one cycle (ends at negedge)
  task automatic tick();
    logic [40:0] e;
    if (reset_n && in_valid && in_ready) begin
      exp_q.push_back(ref_out(in_a, in_b));
      acc_cnt++;
    end
    if (reset_n && out_valid && out_ready) begin
      pop_cnt++;
      check("pop_model_nonempty", 80'(exp_q.size() != 0), 80'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_data", 80'(out_data), 80'(e[39:0]));
        check("pop_sat", 80'(out_sat), 80'(e[40]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(input string tag, input logic [IW-1:0] a, input logic [IW-1:0] b,
                        input logic [OW-1:0] exp_data, input logic exp_sat);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    check({tag, "_ov_k"}, 80'(out_valid), 80'd0);
    tick();
    check({tag, "_ov_k1"}, 80'(out_valid), 80'd0);
    tick();
    check({tag, "_ov_k2"}, 80'(out_valid), 80'd1);
    check({tag, "_data"}, 80'(out_data), 80'(exp_data));
    check({tag, "_sat"}, 80'(out_sat), 80'(exp_sat));
    tick();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 80'(in_ready), 80'd0);
    check("rst_mul_ce", 80'(mul_ce), 80'd0);
    check("rst_din0", 80'(mul_din0), 80'd0);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_out_data", 80'(out_data), 80'd0);
    check("rst_sat_count", 80'(sat_count), 80'd0);
    check("rst_busy", 80'(busy), 80'd0);

    // 1: reset while two ops are in flight
    reset_n = 1'b1;
    tick();
    check("rel_in_ready", 80'(in_ready), 80'd1);
    check("rel_mul_ce", 80'(mul_ce), 80'd1);
    in_valid = 1'b1; in_a = 39'h7F_FFFF_FFFF; in_b = 39'h7F_FFFF_FFFF;
    tick();
    in_a = 39'h1_0000_0000; in_b = 39'h3_0000_0000;
    tick();
    check("inflight_busy", 80'(busy), 80'd1);
    reset_n = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    check("midrst_in_ready", 80'(in_ready), 80'd0);
    check("midrst_mul_ce", 80'(mul_ce), 80'd0);
    check("midrst_busy", 80'(busy), 80'd0);
    reset_n = 1'b1; out_ready = 1'b1;
    tick();
    check("rel2_in_ready", 80'(in_ready), 80'd1);
    check("rel2_sat_count", 80'(sat_count), 80'd0);
    for (int i = 0; i < 4; i++) begin
      check("rel2_no_out_valid", 80'(out_valid), 80'd0);
      tick();
    end

    // 2, 3: basic products and rounding boundary
    single("t2", 39'h1_0000_0000, 39'h2_8000_0000, 40'h2_8000_0000, 1'b0);
    check("t2_busy_idle", 80'(busy), 80'd0);
    single("t3_up", 39'h1, 39'h8000_0000, 40'h1, 1'b0);
    single("t3_down", 39'h1, 39'h7FFF_FFFF, 40'h0, 1'b0);

    // 4: saturation and saturating counter
    single("t4", 39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1);
    check("t4_sat_count1", 80'(sat_count), 80'd1);
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 69999; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
    check("t4_drained", 80'(exp_q.size()), 80'd0);
    check("t4_accepts", 80'(acc_cnt), 80'd69999);
    check("t4_sat_count_max", 80'(sat_count), 80'hFFFF);

    // 5: backpressure fills exactly FIFO_DEPTH credits
    acc_cnt = 0; pop_cnt = 0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = opa[acc_cnt]; in_b = opb[acc_cnt];
      tick();
    end
    check("t5_accepted4", 80'(acc_cnt), 80'd4);
    check("t5_in_ready", 80'(in_ready), 80'd0);
    check("t5_busy", 80'(busy), 80'd1);
    check("t5_out_valid", 80'(out_valid), 80'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && pop_cnt < 6; i++) begin
      if (acc_cnt < 6) begin
        in_valid = 1'b1; in_a = opa[acc_cnt]; in_b = opb[acc_cnt];
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    check("t5_pops", 80'(pop_cnt), 80'd6);
    check("t5_drained", 80'(exp_q.size()), 80'd0);

    // 6: sustained streaming with random operands
    acc_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_a = IW'({$urandom(), $urandom()} >> ($urandom_range(0, 24)));
      in_b = IW'({$urandom(), $urandom()} >> ($urandom_range(0, 24)));
      check("t6_in_ready", 80'(in_ready), 80'd1);
      tick();
    end
    in_valid = 1'b0;
    check("t6_accepts", 80'(acc_cnt), 80'd100);
    check("t6_throughput", 80'(pop_cnt), 80'd97);
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
    check("t6_pops", 80'(pop_cnt), 80'd100);
    check("t6_busy_idle", 80'(busy), 80'd0);
    check("t6_sat_count_hold", 80'(sat_count), 80'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
